// File: rtl/piso_serial_tx.sv
// Parallel-in, serial-out frame transmitter: a start bit (0), N data bits and a stop bit (1).
// Each line bit is held for CLKS_PER_BIT clocks. Words are accepted through a valid/ready handshake.
module piso_serial_tx #(
  parameter int N            = 5,
  parameter int CLKS_PER_BIT = 2,
  parameter bit MSB_FIRST    = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         ser_out,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int BW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST_CLK   = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT   = BW'(N - 1);
  localparam bit            SINGLE_CLK = (CLKS_PER_BIT == 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [N-1:0]  shreg;
  logic [N-1:0]  shifted;
  logic [CW-1:0] clk_cnt;
  logic [BW-1:0] bit_cnt;
  logic          bit_end;

  assign in_ready = (state == IDLE);
  assign bit_end  = (clk_cnt == LAST_CLK);

  always_comb begin
    shifted = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
  end

  // The bit that goes on the line next is always at the head of the register.
  function automatic logic head_bit(input logic [N-1:0] v);
    return MSB_FIRST ? v[N-1] : v[0];
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      shreg   <= '0;
      clk_cnt <= '0;
      bit_cnt <= '0;
      ser_out <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ser_out <= 1'b1;
          busy    <= 1'b0;
          done    <= 1'b0;
          if (in_valid) begin
            shreg   <= in_data;
            state   <= START;
            ser_out <= 1'b0;
            busy    <= 1'b1;
            clk_cnt <= '0;
            bit_cnt <= '0;
          end
        end

        START: begin
          if (bit_end) begin
            clk_cnt <= '0;
            state   <= DATA;
            ser_out <= head_bit(shreg);
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end

        // With one clock per bit the stop bit is also its own last cycle, so done rises on entry.
        DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_cnt == LAST_BIT) begin
              state   <= STOP;
              bit_cnt <= '0;
              ser_out <= 1'b1;
              done    <= SINGLE_CLK;
            end else begin
              shreg   <= shifted;
              bit_cnt <= bit_cnt + BW'(1);
              ser_out <= head_bit(shifted);
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end

        STOP: begin
          if (bit_end) begin
            clk_cnt <= '0;
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
            done    <= ((clk_cnt + CW'(1)) == LAST_CLK);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/piso_serial_tx.md
Name: piso_serial_tx

Overview:
- N-bit parallel-in, serial-out frame transmitter: the serialising end of the team's parallel register datapath.
- Accepts a parallel word through a valid/ready handshake and captures it into an internal shift register.
- Drives the word onto a single line as: start bit (0), N data bits, stop bit (1).
- Each bit is held for a programmable number of clock cycles.

Parameters:
- N, 5, data word width in bits; legal range N >= 1.
- CLKS_PER_BIT, 2, clock cycles each line bit is held; legal range >= 1.
- MSB_FIRST, 1, 1 = transmit bit N-1 first; 0 = transmit bit 0 first.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset; sampled only on the rising edge of clk.
- in_data  input  N  parallel word to transmit.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word; high only in IDLE.
- ser_out  output  1  serial line; idles high.
- busy  output  1  high in START, DATA and STOP.
- done  output  1  one-cycle pulse on the last cycle of the STOP bit.

Behaviour:
- Reset (rst=0 at a clk rising edge):
  - state=IDLE, ser_out=1, busy=0, done=0.
  - Shift register and both counters cleared.
  - in_ready=1 from the first edge that samples rst=0.
- Reset is synchronous. A low-going rst between edges changes nothing until the next rising edge.
- All outputs are registered, except in_ready = (state==IDLE).
- Handshake:
  - A word is accepted on an edge where in_valid=1 and in_ready=1.
  - in_data is latched into the shift register on that edge.
  - Later changes to in_data are ignored until the next acceptance.
- States:
  - IDLE: ser_out=1. On acceptance go to START; bit-clock counter=0, bit counter=0.
  - START: ser_out=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA:
    - ser_out = current data bit: shift register MSB if MSB_FIRST=1, else LSB.
    - Each bit is held for CLKS_PER_BIT cycles; then the register shifts (left for MSB-first, right for LSB-first) and the bit counter increments.
    - After bit N-1 completes, go to STOP.
  - STOP: ser_out=1 for CLKS_PER_BIT cycles. done=1 on the final STOP cycle only, then go to IDLE.
- Timing:
  - Frame length: exactly (N+2)*CLKS_PER_BIT cycles, from the first START cycle to the last STOP cycle inclusive.
  - First START cycle is the cycle after the acceptance edge.
  - Back-to-back words: at least one IDLE cycle between frames. With in_valid held high, the next word is accepted on the edge ending that single IDLE cycle.
- Counter widths:
  - Bit-clock counter: $clog2(CLKS_PER_BIT)+1 bits.
  - Bit counter: $clog2(N)+1 bits.
  - Counters wrap to 0 at each bit boundary; they never overflow for legal parameters.
- CLKS_PER_BIT=1: every bit lasts one cycle and the frame is N+2 cycles. done coincides with the single STOP cycle.
- Reset mid-frame (rst=0 in any state):
  - Abort at that edge: state=IDLE, ser_out=1.
  - No done pulse; the partial word is discarded.
- in_valid while busy: ignored (in_ready=0). Nothing is queued.
- in_valid and rst=0 on the same edge: reset wins and no word is accepted.

Test Plan:
- Default params, rst=0 for 2 edges then rst=1, in_valid=0 -> ser_out=1, busy=0, done=0, in_ready=1 held for 20 cycles.
- Default params, accept in_data=5'b10101 -> ser_out pairs 0,1,0,1,0,1,1 (14 cycles).
  - busy=1 for those 14 cycles.
  - done=1 on cycle 14 only.
  - in_ready=1 on cycle 15.
- MSB_FIRST=0, CLKS_PER_BIT=1, accept 5'b01011 -> ser_out 0,1,1,0,1,0,1 over 7 cycles; done on the 7th cycle.
- Default params, in_valid held high with 5'b10101 then 5'b01010, in_data changed mid-frame to 5'b11111 -> first frame unaffected, one IDLE cycle, second frame data bits 0,1,0,1,0.
- Default params, mid-DATA of 5'b11100: drive rst=0 2 time units after an edge -> ser_out unchanged until the next edge. Then ser_out=1, busy=0, no done; a new word is accepted 1 cycle after rst=1.
- Reset and in_valid=1 on the same edge in IDLE -> no frame starts; ser_out stays 1.
